// File: rtl/usr_sequencer_if.sv
// Command and shift-register control bundle between a command source and usr_sequencer.
// master = command source side, slave = sequencer side.
interface usr_sequencer_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 3
) ();
   logic             cmd_valid;
   logic             cmd_ready;
   logic [2:0]       cmd_op;
   logic [CNT_W-1:0] cmd_cnt;
   logic [WIDTH-1:0] cmd_data;
   logic             abort;
   logic [2:0]       usr_sel;
   logic [WIDTH-1:0] usr_din;
   logic             busy;
   logic             done;
   logic             aborted;

   modport master (
      output cmd_valid, cmd_op, cmd_cnt, cmd_data, abort,
      input  cmd_ready, usr_sel, usr_din, busy, done, aborted
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_cnt, cmd_data, abort,
      output cmd_ready, usr_sel, usr_din, busy, done, aborted
   );
endinterface

// File: rtl/usr_sequencer.sv
// Sequences hold/shift/load commands onto a universal shift register's select and data lines; all outputs registered.
// Define USR_SEQ_QUEUE_EN to add a 2-entry command FIFO that dispatches back-to-back commands without IDLE gaps.
module usr_sequencer #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 3
) (
   input logic            clk,
   input logic            rst_n,
   usr_sequencer_if.slave bus
);
   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

   localparam logic [2:0] OP_HOLD = 3'b000;
   localparam logic [2:0] OP_LOAD = 3'b111;

   state_t           state_q;
   logic [2:0]       sel_q;
   logic [WIDTH-1:0] din_q;
   logic [CNT_W-1:0] cnt_q;
   logic             busy_q;
   logic             done_q;
   logic             aborted_q;
   logic             ready_q;
   logic             ready_d;

   logic             accept;
   logic             idle_or_done;
   logic             disp;
   logic             src_vld;
   logic [2:0]       src_op;
   logic [CNT_W-1:0] src_cnt;
   logic [WIDTH-1:0] src_data;

   assign accept       = bus.cmd_valid && ready_q;
   assign idle_or_done = (state_q == IDLE) || (state_q == DONE);
   assign disp         = idle_or_done && src_vld;

`ifdef USR_SEQ_QUEUE_EN
   logic [2:0]       q_op_q   [2];
   logic [CNT_W-1:0] q_cnt_q  [2];
   logic [WIDTH-1:0] q_data_q [2];
   logic             wr_ptr_q;
   logic             rd_ptr_q;
   logic [1:0]       count_q;
   logic [1:0]       count_d;
   logic             have;
   logic             flush;
   logic             push;
   logic             pop;

   // An empty FIFO lets an arriving command bypass straight into dispatch.
   always_comb begin
      have     = (count_q != 2'd0);
      flush    = bus.abort && ((state_q == LOAD) || (state_q == SHIFT));
      src_vld  = have || accept;
      src_op   = have ? q_op_q[rd_ptr_q]   : bus.cmd_op;
      src_cnt  = have ? q_cnt_q[rd_ptr_q]  : bus.cmd_cnt;
      src_data = have ? q_data_q[rd_ptr_q] : bus.cmd_data;
      push     = accept && !flush && !(idle_or_done && !have);
      pop      = idle_or_done && have;
      count_d  = flush ? 2'd0 : (count_q + {1'b0, push} - {1'b0, pop});
      ready_d  = (count_d != 2'd2);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         count_q <= count_d;
         if (flush) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
         end else begin
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         q_op_q[wr_ptr_q]   <= bus.cmd_op;
         q_cnt_q[wr_ptr_q]  <= bus.cmd_cnt;
         q_data_q[wr_ptr_q] <= bus.cmd_data;
      end
   end
`else
   always_comb begin
      src_vld  = accept;
      src_op   = bus.cmd_op;
      src_cnt  = bus.cmd_cnt;
      src_data = bus.cmd_data;
      ready_d  = idle_or_done && !disp;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         sel_q     <= OP_HOLD;
         din_q     <= '0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
         ready_q   <= 1'b1;
      end else begin
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
         ready_q   <= ready_d;
         if (disp) begin
            cnt_q <= src_cnt;
            din_q <= src_data;
            if (src_op == OP_LOAD) begin
               state_q <= LOAD;
               sel_q   <= OP_LOAD;
               busy_q  <= 1'b1;
            end else if ((src_op != OP_HOLD) && (src_cnt != '0)) begin
               state_q <= SHIFT;
               sel_q   <= src_op;
               busy_q  <= 1'b1;
            end else begin
               state_q <= DONE;
               sel_q   <= OP_HOLD;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
            end
         end else begin
            case (state_q)
               IDLE: state_q <= IDLE;
               LOAD: begin
                  state_q   <= DONE;
                  sel_q     <= OP_HOLD;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
                  aborted_q <= bus.abort;
               end
               SHIFT: begin
                  cnt_q <= cnt_q - CNT_W'(1);
                  // An abort on the final shift cycle still reports as aborted.
                  if (bus.abort || (cnt_q == CNT_W'(1))) begin
                     state_q   <= DONE;
                     sel_q     <= OP_HOLD;
                     busy_q    <= 1'b0;
                     done_q    <= 1'b1;
                     aborted_q <= bus.abort;
                  end
               end
               DONE:    state_q <= IDLE;
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign bus.cmd_ready = ready_q;
   assign bus.usr_sel   = sel_q;
   assign bus.usr_din   = din_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.aborted   = aborted_q;
endmodule

// File: tb/tb_usr_sequencer.sv
// Self-checking bench for usr_sequencer: directed and random commands against a per-cycle expected trace.
module tb_usr_sequencer;
   localparam int WIDTH = 8;
   localparam int CNT_W = 3;
`ifdef USR_SEQ_QUEUE_EN
   localparam logic READY_BUSY = 1'b1;
`else
   localparam logic READY_BUSY = 1'b0;
`endif

   typedef struct packed {
      logic [2:0]       sel;
      logic [WIDTH-1:0] din;
      logic             busy;
      logic             done;
      logic             aborted;
   } rec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   checks = 0;
   int   failures = 0;
   rec_t exp_q[$];

   usr_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();
   usr_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic rec_t mk(input logic [2:0] s, input logic [WIDTH-1:0] d,
                               input logic b, input logic dn, input logic ab);
      rec_t r;
      r.sel = s; r.din = d; r.busy = b; r.done = dn; r.aborted = ab;
      return r;
   endfunction

   // Expected cycles from acceptance+1 until the done pulse. abort_at = 1-based cycle index carrying abort (0 = none).
   function automatic void model(input logic [2:0] op, input int cnt, input logic [WIDTH-1:0] data, input int abort_at);
      int  n;
      bit  ab;
      if (op == 3'b111) begin
         exp_q.push_back(mk(3'b111, data, 1'b1, 1'b0, 1'b0));
         exp_q.push_back(mk(3'b000, data, 1'b0, 1'b1, abort_at == 1));
      end else if (op != 3'b000 && cnt > 0) begin
         ab = (abort_at > 0) && (abort_at <= cnt);
         n  = ab ? abort_at : cnt;
         for (int i = 0; i < n; i++) exp_q.push_back(mk(op, data, 1'b1, 1'b0, 1'b0));
         exp_q.push_back(mk(3'b000, data, 1'b0, 1'b1, ab));
      end else begin
         exp_q.push_back(mk(3'b000, data, 1'b0, 1'b1, 1'b0));
      end
   endfunction

   task automatic run_cmd(input logic [2:0] op, input logic [CNT_W-1:0] cnt, input logic [WIDTH-1:0] data,
                          input int abort_at, input bit abort_on_accept);
      int   guard;
      rec_t e;
      exp_q.delete();
      model(op, int'(cnt), data, abort_at);
      guard = 0;
      while (bus.cmd_ready !== 1'b1 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      chk("ready_before_cmd", 32'(bus.cmd_ready), 32'd1);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_cnt   = cnt;
      bus.cmd_data  = data;
      bus.abort     = abort_on_accept;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      bus.abort     = 1'b0;
      foreach (exp_q[i]) begin
         e = exp_q[i];
         chk("usr_sel", 32'(bus.usr_sel), 32'(e.sel));
         chk("usr_din", 32'(bus.usr_din), 32'(e.din));
         chk("busy", 32'(bus.busy), 32'(e.busy));
         chk("done", 32'(bus.done), 32'(e.done));
         chk("aborted", 32'(bus.aborted), 32'(e.aborted));
         chk("cmd_ready_active", 32'(bus.cmd_ready), 32'(READY_BUSY));
         bus.abort = (abort_at == i + 1);
         @(negedge clk);
         bus.abort = 1'b0;
      end
      chk("idle_sel", 32'(bus.usr_sel), 32'd0);
      chk("idle_busy", 32'(bus.busy), 32'd0);
      chk("idle_done", 32'(bus.done), 32'd0);
      chk("idle_ready", 32'(bus.cmd_ready), 32'd1);
   endtask

`ifdef USR_SEQ_QUEUE_EN
   logic [2:0]       q_ops  [3];
   logic [CNT_W-1:0] q_cnts [3];
   logic [WIDTH-1:0] q_dats [3];
`endif

   initial begin
      int   c;
      int   ab;
      int   idx;
      int   k;
      logic acc;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 3'b000;
      bus.cmd_cnt   = '0;
      bus.cmd_data  = '0;
      bus.abort     = 1'b0;
      idx = 0;
      k   = 0;
      acc = 1'b0;

      #2 rst_n = 1'b0;
      #1;
      chk("rst_sel", 32'(bus.usr_sel), 32'd0);
      chk("rst_din", 32'(bus.usr_din), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_aborted", 32'(bus.aborted), 32'd0);
      chk("rst_ready", 32'(bus.cmd_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run_cmd(3'b111, 3'd0, 8'hA5, 0, 1'b0);
      run_cmd(3'b101, 3'd5, 8'h11, 0, 1'b0);
      run_cmd(3'b010, 3'd0, 8'h22, 0, 1'b0);
      run_cmd(3'b001, 3'd7, 8'h33, 0, 1'b0);
      run_cmd(3'b000, 3'd3, 8'h44, 1, 1'b0);
      run_cmd(3'b100, 3'd6, 8'h5A, 3, 1'b0);
      run_cmd(3'b111, 3'd0, 8'hC3, 1, 1'b0);
      run_cmd(3'b011, 3'd2, 8'h77, 0, 1'b1);
      run_cmd(3'b110, 3'd4, 8'h88, 4, 1'b0);

      for (int r = 0; r < 30; r++) begin
         c  = int'($urandom_range(0, 7));
         ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, c + 1)) : 0;
         run_cmd(3'($urandom_range(0, 7)), CNT_W'(c), WIDTH'($urandom), ab, 1'($urandom_range(0, 1)));
      end

      // Reset in the middle of a shift must drop the command silently.
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 3'b100;
      bus.cmd_cnt   = 3'd6;
      bus.cmd_data  = 8'h9C;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      @(negedge clk);
      chk("mid_shift_sel", 32'(bus.usr_sel), 32'd4);
      chk("mid_shift_busy", 32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_sel", 32'(bus.usr_sel), 32'd0);
      chk("rst_mid_din", 32'(bus.usr_din), 32'd0);
      chk("rst_mid_busy", 32'(bus.busy), 32'd0);
      chk("rst_mid_done", 32'(bus.done), 32'd0);
      chk("rst_mid_aborted", 32'(bus.aborted), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("post_rst_done", 32'(bus.done), 32'd0);
         chk("post_rst_aborted", 32'(bus.aborted), 32'd0);
         chk("post_rst_sel", 32'(bus.usr_sel), 32'd0);
      end

`ifdef USR_SEQ_QUEUE_EN
      q_ops[0] = 3'b111; q_cnts[0] = 3'd0; q_dats[0] = 8'h3C;
      q_ops[1] = 3'b011; q_cnts[1] = 3'd2; q_dats[1] = 8'h00;
      q_ops[2] = 3'b111; q_cnts[2] = 3'd0; q_dats[2] = 8'h0F;
      exp_q.delete();
      for (int i = 0; i < 3; i++) model(q_ops[i], int'(q_cnts[i]), q_dats[i], 0);
      idx = 0;
      k   = 0;
      for (int cyc = 0; cyc < 60 && idx < exp_q.size(); cyc++) begin
         if (bus.busy || bus.done || idx > 0) begin
            chk("q_sel", 32'(bus.usr_sel), 32'(exp_q[idx].sel));
            chk("q_din", 32'(bus.usr_din), 32'(exp_q[idx].din));
            chk("q_busy", 32'(bus.busy), 32'(exp_q[idx].busy));
            chk("q_done", 32'(bus.done), 32'(exp_q[idx].done));
            idx++;
         end
         if (k < 3) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_op    = q_ops[k];
            bus.cmd_cnt   = q_cnts[k];
            bus.cmd_data  = q_dats[k];
         end else begin
            bus.cmd_valid = 1'b0;
         end
         acc = bus.cmd_valid && bus.cmd_ready;
         @(negedge clk);
         if (acc) k++;
      end
      bus.cmd_valid = 1'b0;
      chk("q_seq_len", 32'(idx), 32'(exp_q.size()));
      chk("q_all_pushed", 32'(k), 32'd3);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
